// File: rtl/dizy_inv_core_pkg.sv
// dizy_inv_core_pkg
//   Shared definitions for the DIZY forward/inverse round datapaths:
//   default geometry, round-constant schedule, 5-bit S-box pair and the
//   controller state encoding.
//   Layout assumptions:
//     - state is split into 5-bit S-box groups (group g = bits [5g+4:5g])
//     - the bit permutation works on PERM_SIZE-bit groups and sends bit i
//       of a group to bit (i*PERM_STRIDE) mod PERM_SIZE, so PERM_SIZE must
//       be coprime with PERM_STRIDE
//     - group mixing is y[g] = x[g] ^ x[g-1] over 5-bit groups (y[0] = x[0])
package dizy_inv_core_pkg;

  localparam int DIZY_SIZE_STATE = 40;
  localparam int DIZY_PERM_SIZE  = 10;
  localparam int DIZY_N_ROUNDS   = 8;
  localparam int PERM_STRIDE     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dizy_state_e;

  // Round-constant schedule; rounds beyond 15 would alias, so the
  // engine supports at most 16 rounds.
  function automatic logic [3:0] dizy_rc(input logic [3:0] r);
    logic [3:0] rc;
    case (r)
      4'd0:    rc = 4'h1;
      4'd1:    rc = 4'h3;
      4'd2:    rc = 4'h7;
      4'd3:    rc = 4'hf;
      4'd4:    rc = 4'he;
      4'd5:    rc = 4'hd;
      4'd6:    rc = 4'hb;
      4'd7:    rc = 4'h6;
      4'd8:    rc = 4'hc;
      4'd9:    rc = 4'h9;
      4'd10:   rc = 4'h2;
      4'd11:   rc = 4'h5;
      4'd12:   rc = 4'ha;
      4'd13:   rc = 4'h4;
      4'd14:   rc = 4'h8;
      default: rc = 4'h0;
    endcase
    return rc;
  endfunction

  // Forward S-box: s = 7*x + 3 mod 32 (7 is odd, so this is a bijection).
  function automatic logic [4:0] dizy_sbox5(input logic [4:0] x);
    return (x * 5'd7) + 5'd3;
  endfunction

  // Inverse S-box: x = 23*(s - 3) mod 32, since 7*23 = 161 = 1 mod 32.
  function automatic logic [4:0] dizy_inv_sbox5(input logic [4:0] s);
    return (s - 5'd3) * 5'd23;
  endfunction

endpackage

// File: rtl/dizy_inv_core_inv_round.sv
// dizy_inv_core_inv_round
//   One combinational inverse DIZY round:
//     state_out = inv_sbox(inv_perm(inv_mix_groups(state_in))) ^ RC
//   i.e. the forward round mix(perm(sbox(x ^ RC))) undone in reverse order.
// Ports:
//   rc        in   4           round constant, replicated as {1'b0, rc} per 5-bit group
//   state_in  in   SIZE_STATE  state after the forward round
//   state_out out  SIZE_STATE  state before the forward round
module dizy_inv_core_inv_round
  import dizy_inv_core_pkg::*;
#(
  parameter int SIZE_STATE = DIZY_SIZE_STATE,
  parameter int PERM_SIZE  = DIZY_PERM_SIZE
) (
  input  logic [3:0]            rc,
  input  logic [SIZE_STATE-1:0] state_in,
  output logic [SIZE_STATE-1:0] state_out
);

  localparam int N_GRP  = SIZE_STATE / 5;
  localparam int N_PGRP = SIZE_STATE / PERM_SIZE;

  logic [SIZE_STATE-1:0] unmixed;
  logic [SIZE_STATE-1:0] unpermed;
  logic [SIZE_STATE-1:0] unsboxed;
  logic [4:0]            mix_acc;

  // inv_mix_groups: forward is y[g] = x[g] ^ x[g-1], so x[g] is the
  // running XOR of y[0..g].
  always_comb begin
    mix_acc = '0;
    unmixed = '0;
    for (int g = 0; g < N_GRP; g++) begin
      mix_acc = mix_acc ^ state_in[g*5 +: 5];
      unmixed[g*5 +: 5] = mix_acc;
    end
  end

  // inv_perm: forward moved bit i to bit (i*PERM_STRIDE) mod PERM_SIZE.
  for (genvar p = 0; p < N_PGRP; p++) begin : g_inv_perm
    for (genvar i = 0; i < PERM_SIZE; i++) begin : g_bit
      assign unpermed[p*PERM_SIZE + i] =
        unmixed[p*PERM_SIZE + ((i * PERM_STRIDE) % PERM_SIZE)];
    end
  end

  for (genvar g = 0; g < N_GRP; g++) begin : g_inv_sbox
    assign unsboxed[g*5 +: 5] = dizy_inv_sbox5(unpermed[g*5 +: 5]);
  end

  assign state_out = unsboxed ^ {N_GRP{{1'b0, rc}}};

endmodule

// File: rtl/dizy_inv_core.sv
// dizy_inv_core
//   Iterative DIZY inverse-permutation engine. Accepts a state word, undoes
//   N_ROUNDS forward rounds (round N_ROUNDS-1 first, round 0 last) and
//   presents the recovered state until the consumer takes it.
//   Optional build macro DIZY_INV_UNROLL2_EN: two inverse rounds per clock
//   (N_ROUNDS must then be even); results are identical to the default build.
// Ports:
//   clk        in   1           rising-edge clock
//   rst        in   1           synchronous active-high reset
//   in_valid   in   1           in_data is valid
//   in_ready   out  1           core is idle and can accept a state
//   in_data    in   SIZE_STATE  ciphertext-side state
//   out_valid  out  1           out_data holds a finished result
//   out_ready  in   1           consumer accepts the result
//   out_data   out  SIZE_STATE  recovered state (registered)
//   busy       out  1           inverse rounds in progress
//
// state | meaning
// IDLE  | waiting for a block, in_ready=1
// RUN   | applying inverse rounds, busy=1
// DONE  | result held on out_data, out_valid=1 until out_ready
module dizy_inv_core
  import dizy_inv_core_pkg::*;
#(
  parameter int SIZE_STATE = DIZY_SIZE_STATE,
  parameter int PERM_SIZE  = DIZY_PERM_SIZE,
  parameter int N_ROUNDS   = DIZY_N_ROUNDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIZE_STATE-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIZE_STATE-1:0] out_data,
  output logic                  busy
);

  // A single-round build still needs a 1-bit counter.
  localparam int CNT_W = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1;

  dizy_state_e           state_cur;
  dizy_state_e           state_nxt;
  logic [SIZE_STATE-1:0] state_q;
  logic [SIZE_STATE-1:0] round_out;
  logic [CNT_W-1:0]      rnd_q;
  logic [3:0]            rc_hi;
  logic                  last_round;

  assign rc_hi = dizy_rc(4'(rnd_q));

`ifdef DIZY_INV_UNROLL2_EN
  localparam int RND_STEP = 2;

  logic [SIZE_STATE-1:0] mid_state;
  logic [CNT_W-1:0]      rnd_lo;
  logic [3:0]            rc_lo;

  if ((N_ROUNDS % 2) != 0) begin : g_odd_rounds
    $error("dizy_inv_core: two rounds per cycle needs an even N_ROUNDS");
  end

  assign rnd_lo = rnd_q - 1'b1;
  assign rc_lo  = dizy_rc(4'(rnd_lo));

  dizy_inv_core_inv_round #(
    .SIZE_STATE (SIZE_STATE),
    .PERM_SIZE  (PERM_SIZE)
  ) u_inv_round_hi (
    .rc        (rc_hi),
    .state_in  (state_q),
    .state_out (mid_state)
  );

  dizy_inv_core_inv_round #(
    .SIZE_STATE (SIZE_STATE),
    .PERM_SIZE  (PERM_SIZE)
  ) u_inv_round_lo (
    .rc        (rc_lo),
    .state_in  (mid_state),
    .state_out (round_out)
  );

  // Counter visits N-1, N-3, ..., 1; the pair ending in round 0 is last.
  assign last_round = (rnd_q == CNT_W'(1));
`else
  localparam int RND_STEP = 1;

  dizy_inv_core_inv_round #(
    .SIZE_STATE (SIZE_STATE),
    .PERM_SIZE  (PERM_SIZE)
  ) u_inv_round (
    .rc        (rc_hi),
    .state_in  (state_q),
    .state_out (round_out)
  );

  assign last_round = (rnd_q == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_cur <= ST_IDLE;
    end else begin
      state_cur <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_cur;
    case (state_cur)
      ST_IDLE: if (in_valid)   state_nxt = ST_RUN;
      ST_RUN:  if (last_round) state_nxt = ST_DONE;
      ST_DONE: if (out_ready)  state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_cur)
      ST_IDLE: in_ready  = 1'b1;
      ST_RUN:  busy      = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // The working register doubles as the output register; it only loads
  // from in_data in IDLE, so inputs during RUN/DONE are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      case (state_cur)
        ST_IDLE: begin
          if (in_valid) begin
            state_q <= in_data;
            rnd_q   <= CNT_W'(N_ROUNDS - 1);
          end
        end
        ST_RUN: begin
          state_q <= round_out;
          rnd_q   <= rnd_q - CNT_W'(RND_STEP);
        end
        default: begin
          state_q <= state_q;
          rnd_q   <= rnd_q;
        end
      endcase
    end
  end

  assign out_data = state_q;

endmodule

// File: tb/tb_dizy_inv_core.sv
// tb_dizy_inv_core
//   Encrypts states with a forward-round reference model written directly
//   from the round definition, feeds the results to the inverse core and
//   expects the original states back with the documented timing.
module tb_dizy_inv_core;

  localparam int SZ = 40;
  localparam int PS = 10;
  localparam int NR = 8;
  localparam int NG = SZ / 5;
`ifdef DIZY_INV_UNROLL2_EN
  localparam int LAT = NR / 2 + 1;
`else
  localparam int LAT = NR + 1;
`endif

  int rc_tab[16] = '{1, 3, 7, 15, 14, 13, 11, 6, 12, 9, 2, 5, 10, 4, 8, 0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SZ-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SZ-1:0] out_data;
  logic          busy;

  logic          in_valid_1 = 1'b0;
  logic          in_ready_1;
  logic [SZ-1:0] in_data_1 = '0;
  logic          out_valid_1;
  logic          out_ready_1 = 1'b0;
  logic [SZ-1:0] out_data_1;
  logic          busy_1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dizy_inv_core #(.SIZE_STATE(SZ), .PERM_SIZE(PS), .N_ROUNDS(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

`ifndef DIZY_INV_UNROLL2_EN
  dizy_inv_core #(.SIZE_STATE(SZ), .PERM_SIZE(PS), .N_ROUNDS(1)) dut_1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_1),
    .in_ready  (in_ready_1),
    .in_data   (in_data_1),
    .out_valid (out_valid_1),
    .out_ready (out_ready_1),
    .out_data  (out_data_1),
    .busy      (busy_1)
  );
`endif

  // Forward round: mix_groups(perm(sbox(x ^ RC(r)))).
  function automatic logic [SZ-1:0] fwd_round(input logic [SZ-1:0] x, input int r);
    logic [SZ-1:0] a, b, c;
    int v;
    a = '0; b = '0; c = '0;
    for (int g = 0; g < NG; g++) begin
      v = int'(x[g*5 +: 5]) ^ rc_tab[r];
      a[g*5 +: 5] = 5'((v * 7 + 3) % 32);
    end
    for (int p = 0; p < SZ / PS; p++)
      for (int i = 0; i < PS; i++)
        b[p*PS + (i * 3) % PS] = a[p*PS + i];
    for (int g = 0; g < NG; g++) begin
      if (g == 0) c[4:0] = b[4:0];
      else        c[g*5 +: 5] = b[g*5 +: 5] ^ b[(g-1)*5 +: 5];
    end
    return c;
  endfunction

  function automatic logic [SZ-1:0] encrypt(input logic [SZ-1:0] x, input int n);
    logic [SZ-1:0] y;
    y = x;
    for (int r = 0; r < n; r++) y = fwd_round(y, r);
    return y;
  endfunction

  function automatic logic [SZ-1:0] rand_state();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[SZ-1:0];
  endfunction

  // Hand a block to the core and wait (bounded) for out_valid; the result is
  // left pending. lat counts cycles from the accept cycle to out_valid.
  task automatic send_block(input logic [SZ-1:0] ct, output int lat, output int busy_n,
                            output bit ok);
    int n;
    in_data  = ct;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!out_valid && lat < 100) begin
      busy_n += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
    ok = out_valid;
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total += 4;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_round_trip();
    logic [SZ-1:0] x, ct;
    int lat, bn;
    bit ok;
    for (int k = 0; k < 12; k++) begin
      if (k == 0)      x = '0;
      else if (k == 1) x = '1;
      else             x = rand_state();
      ct = encrypt(x, NR);
      send_block(ct, lat, bn, ok);
      total += 4;
      if (ok !== 1'b1) begin bad++; $display("FAIL rt_timeout[%0d] got=%b exp=1", k, ok); end
      if (out_data !== x) begin bad++; $display("FAIL rt_data[%0d] got=%h exp=%h", k, out_data, x); end
      if (lat != LAT) begin bad++; $display("FAIL rt_latency[%0d] got=%0d exp=%0d", k, lat, LAT); end
      if (bn != LAT - 1) begin bad++; $display("FAIL rt_busy[%0d] got=%0d exp=%0d", k, bn, LAT - 1); end
      take_output();
    end
  endtask

  task automatic test_backpressure();
    logic [SZ-1:0] x, held;
    int lat, bn, drift, rdy, vld;
    bit ok;
    x = rand_state();
    send_block(encrypt(x, NR), lat, bn, ok);
    held = out_data;
    drift = 0; rdy = 0; vld = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_data !== held) drift++;
      if (in_ready !== 1'b0) rdy++;
      if (out_valid !== 1'b1) vld++;
    end
    total += 4;
    if (held !== x) begin bad++; $display("FAIL bp_data got=%h exp=%h", held, x); end
    if (drift != 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0 changed cycles", drift); end
    if (rdy != 0) begin bad++; $display("FAIL bp_in_ready got=%0d exp=0 high cycles", rdy); end
    if (vld != 0) begin bad++; $display("FAIL bp_out_valid got=%0d exp=0 low cycles", vld); end
    take_output();
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_ignored_input();
    logic [SZ-1:0] x;
    int n, extra;
    x = rand_state();
    in_data = encrypt(x, NR);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    in_data = ~in_data;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    total += 2;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL ign_timeout got=%b exp=1", out_valid); end
    if (out_data !== x) begin bad++; $display("FAIL ign_data got=%h exp=%h", out_data, x); end
    take_output();
    extra = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      if (out_valid || busy) extra++;
      @(posedge clk); #1;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL ign_extra_output got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    logic [SZ-1:0] x;
    int lat, bn;
    bit ok;
    in_data = encrypt(rand_state(), NR);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef DIZY_INV_UNROLL2_EN
    @(posedge clk); #1;
`else
    repeat (NR - 1 - NR / 2) begin @(posedge clk); #1; end
`endif
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total += 4;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    if (out_data !== '0) begin bad++; $display("FAIL mid_out_data got=%h exp=0", out_data); end
    x = rand_state();
    send_block(encrypt(x, NR), lat, bn, ok);
    total += 2;
    if (out_data !== x) begin bad++; $display("FAIL mid_after_data got=%h exp=%h", out_data, x); end
    if (lat != LAT) begin bad++; $display("FAIL mid_after_latency got=%0d exp=%0d", lat, LAT); end
    take_output();
  endtask

  task automatic test_back_to_back();
    logic [SZ-1:0] xs[4];
    logic [SZ-1:0] cts[4];
    int acc_cyc[4];
    int idx, outs;
    bit acc_now;
    for (int i = 0; i < 4; i++) begin
      xs[i] = rand_state();
      cts[i] = encrypt(xs[i], NR);
      acc_cyc[i] = 0;
    end
    idx = 0; outs = 0;
    out_ready = 1'b1;
    in_data = cts[0];
    in_valid = 1'b1;
    for (int c = 0; c < 200 && outs < 4; c++) begin
      acc_now = in_ready && in_valid;
      if (out_valid) begin
        total++;
        if (out_data !== xs[outs]) begin
          bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", outs, out_data, xs[outs]);
        end
        outs++;
      end
      @(posedge clk); #1;
      if (acc_now) begin
        acc_cyc[idx] = c;
        idx++;
        if (idx < 4) in_data = cts[idx];
        else         in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++;
    if (outs != 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", outs); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (acc_cyc[i+1] - acc_cyc[i] != LAT + 1) begin
        bad++; $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", i, acc_cyc[i+1] - acc_cyc[i], LAT + 1);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_round();
`ifndef DIZY_INV_UNROLL2_EN
    logic [SZ-1:0] x;
    int lat, bn;
    for (int k = 0; k < 3; k++) begin
      x = rand_state();
      in_data_1 = fwd_round(x, 0);
      in_valid_1 = 1'b1;
      @(posedge clk); #1;
      in_valid_1 = 1'b0;
      lat = 1; bn = 0;
      while (!out_valid_1 && lat < 50) begin
        bn += int'(busy_1);
        @(posedge clk); #1;
        lat++;
      end
      total += 3;
      if (out_data_1 !== x) begin bad++; $display("FAIL one_data[%0d] got=%h exp=%h", k, out_data_1, x); end
      if (bn != 1) begin bad++; $display("FAIL one_busy[%0d] got=%0d exp=1", k, bn); end
      if (lat != 2) begin bad++; $display("FAIL one_latency[%0d] got=%0d exp=2", k, lat); end
      out_ready_1 = 1'b1;
      @(posedge clk); #1;
      out_ready_1 = 1'b0;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_backpressure();
    test_ignored_input();
    test_reset_mid();
    test_back_to_back();
    test_single_round();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
